// File: rtl/rv_cache_arb_if.sv
// rtl/rv_cache_arb_if.sv - requester and cache-port signal bundle for rv_cache_arb
interface rv_cache_arb_if;
    logic [31:0] i_ireq_addr;
    logic        i_ireq_read;
    logic [31:0] o_ireq_data;
    logic        o_ireq_ack;

    logic [31:0] i_dreq_addr;
    logic        i_dreq_read;
    logic        i_dreq_write;
    logic [3:0]  i_dreq_write_sel;
    logic [31:0] i_dreq_write_data;
    logic [31:0] o_dreq_data;
    logic        o_dreq_ack;

    logic [31:0] o_cache_addr;
    logic [31:0] o_cache_write_data;
    logic        o_cache_read;
    logic        o_cache_write;
    logic [3:0]  o_cache_write_sel;
    logic [31:0] i_cache_data;
    logic        i_cache_ack;

    logic [1:0]  o_grant;
    logic        o_timeout;
    logic        o_hit_ok;

    modport master (
        input  i_ireq_addr, i_ireq_read,
        output o_ireq_data, o_ireq_ack,
        input  i_dreq_addr, i_dreq_read, i_dreq_write, i_dreq_write_sel, i_dreq_write_data,
        output o_dreq_data, o_dreq_ack,
        output o_cache_addr, o_cache_write_data, o_cache_read, o_cache_write, o_cache_write_sel,
        input  i_cache_data, i_cache_ack,
        output o_grant, o_timeout, o_hit_ok
    );

    modport slave (
        output i_ireq_addr, i_ireq_read,
        input  o_ireq_data, o_ireq_ack,
        output i_dreq_addr, i_dreq_read, i_dreq_write, i_dreq_write_sel, i_dreq_write_data,
        input  o_dreq_data, o_dreq_ack,
        input  o_cache_addr, o_cache_write_data, o_cache_read, o_cache_write, o_cache_write_sel,
        output i_cache_data, i_cache_ack,
        input  o_grant, o_timeout, o_hit_ok
    );
endinterface

// File: rtl/rv_cache_arb.sv
// rtl/rv_cache_arb.sv - instr/data arbiter and sequencer for the shared cache port
module rv_cache_arb #(
    parameter logic [3:0] ADDR_HI     = 4'b0,
    parameter int         TIMEOUT_BIT = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    rv_cache_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    // Watchdog counts serve cycles from 0, so the final permitted cycle sees this value.
    localparam logic [TIMEOUT_BIT-1:0] WD_LAST = TIMEOUT_BIT'((1 << TIMEOUT_BIT) - 2);

    state_t                 state_q, state_d;
    logic                   last_data_q;
    logic [TIMEOUT_BIT-1:0] wd_q;
    logic                   timeout_q;
    logic [31:0]            addr_q, wdata_q, idata_q, ddata_q;
    logic [3:0]             sel_q;
    logic                   read_q, write_q;
    logic                   d_pend, i_pend, finish, abort;

    assign d_pend = bus.i_dreq_read | bus.i_dreq_write;
    assign i_pend = bus.i_ireq_read;

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_pend && (!i_pend || !last_data_q)) state_d = SERVE_D;
                else if (i_pend)                         state_d = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (bus.i_cache_ack) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (wd_q == WD_LAST) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            last_data_q <= 1'b1;
            wd_q        <= '0;
            timeout_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            idata_q     <= '0;
            ddata_q     <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= abort;
            if (state_q == IDLE && state_d == SERVE_I) begin
                addr_q      <= bus.i_ireq_addr;
                wdata_q     <= '0;
                sel_q       <= 4'hF;
                read_q      <= 1'b1;
                write_q     <= 1'b0;
                last_data_q <= 1'b0;
                wd_q        <= '0;
            end
            if (state_q == IDLE && state_d == SERVE_D) begin
                addr_q      <= bus.i_dreq_addr;
                wdata_q     <= bus.i_dreq_write ? bus.i_dreq_write_data : 32'h0;
                sel_q       <= bus.i_dreq_write ? bus.i_dreq_write_sel : 4'hF;
                read_q      <= !bus.i_dreq_write;
                write_q     <= bus.i_dreq_write;
                last_data_q <= 1'b1;
                wd_q        <= '0;
            end
            if (state_q == SERVE_I || state_q == SERVE_D) begin
                wd_q <= wd_q + 1'b1;
            end
            // Writes and aborted transfers return zero to the requester.
            if (finish || abort) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
                if (state_q == SERVE_D) ddata_q <= (finish && !write_q) ? bus.i_cache_data : 32'h0;
                else                    idata_q <= finish ? bus.i_cache_data : 32'h0;
            end
        end
    end

    assign bus.o_cache_addr       = addr_q;
    assign bus.o_cache_write_data = wdata_q;
    assign bus.o_cache_write_sel  = sel_q;
    assign bus.o_cache_read       = read_q;
    assign bus.o_cache_write      = write_q;
    assign bus.o_ireq_data        = idata_q;
    assign bus.o_dreq_data        = ddata_q;
    assign bus.o_ireq_ack         = (state_q == DONE) && !last_data_q;
    assign bus.o_dreq_ack         = (state_q == DONE) && last_data_q;
    assign bus.o_grant            = {state_q == SERVE_D, state_q == SERVE_I};
    assign bus.o_timeout          = timeout_q;
    assign bus.o_hit_ok           = (addr_q[31:28] == ADDR_HI) && (read_q || write_q);
endmodule

// File: tb/tb_rv_cache_arb.sv
// tb/tb_rv_cache_arb.sv - self-checking bench for rv_cache_arb
module tb_rv_cache_arb;
    localparam int WD_LIMIT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_cache_arb_if bus();

    rv_cache_arb #(.ADDR_HI(4'b0), .TIMEOUT_BIT(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit m_last_data;

    task automatic idle_inputs();
        bus.i_ireq_addr = 0; bus.i_ireq_read = 0;
        bus.i_dreq_addr = 0; bus.i_dreq_read = 0; bus.i_dreq_write = 0;
        bus.i_dreq_write_sel = 0; bus.i_dreq_write_data = 0;
        bus.i_cache_data = 0; bus.i_cache_ack = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(output bit ok);
        int w = 0;
        while (bus.o_grant == 2'b00 && w < 4) begin
            @(negedge clk);
            w++;
        end
        ok = (bus.o_grant != 2'b00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step(); step();
        rst = 1'b0;
        m_last_data = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step(); step();
        @(negedge clk);
        n_cmp++;
        if ({bus.o_cache_read, bus.o_cache_write, bus.o_cache_write_sel, bus.o_grant,
             bus.o_ireq_ack, bus.o_dreq_ack, bus.o_timeout, bus.o_hit_ok} !== 14'h0) begin
            n_bad++; $display("FAIL reset_ctrl: got strobes/grant/acks nonzero");
        end
        n_cmp++;
        if ({bus.o_cache_addr, bus.o_cache_write_data, bus.o_ireq_data, bus.o_dreq_data} !== 128'h0) begin
            n_bad++; $display("FAIL reset_data: got nonzero addr/data, expected 0");
        end
        step();
        rst = 1'b0;
        m_last_data = 1'b1;
    endtask

    task automatic test_instr_read();
        bit ok;
        bus.i_ireq_addr = 32'h0000_0010; bus.i_ireq_read = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.o_cache_read !== 1'b0) begin n_bad++; $display("FAIL ir_early_strobe: got %b expected 0", bus.o_cache_read); end
        step();
        bus.i_cache_ack = 1'b1; bus.i_cache_data = 32'h1234_5678;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_cache_read, bus.o_cache_write, bus.o_cache_write_sel, bus.o_grant, bus.o_hit_ok} !== 9'b1_0_1111_01_1) begin
            n_bad++; $display("FAIL ir_strobes: got r%b w%b sel%h g%b hit%b expected r1 w0 self g01 hit1",
                bus.o_cache_read, bus.o_cache_write, bus.o_cache_write_sel, bus.o_grant, bus.o_hit_ok);
        end
        n_cmp++;
        if (bus.o_cache_addr !== 32'h0000_0010) begin n_bad++; $display("FAIL ir_addr: got %h expected 00000010", bus.o_cache_addr); end
        step();
        bus.i_cache_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_ireq_ack, bus.o_dreq_ack, bus.o_grant, bus.o_cache_read} !== 5'b1_0_00_0) begin
            n_bad++; $display("FAIL ir_ack: got iack%b dack%b g%b r%b expected 1 0 00 0",
                bus.o_ireq_ack, bus.o_dreq_ack, bus.o_grant, bus.o_cache_read);
        end
        n_cmp++;
        if (bus.o_ireq_data !== 32'h1234_5678) begin n_bad++; $display("FAIL ir_data: got %h expected 12345678", bus.o_ireq_data); end
        bus.i_ireq_read = 1'b0;
        step();
        @(negedge clk);
        n_cmp++;
        if (bus.o_ireq_ack !== 1'b0) begin n_bad++; $display("FAIL ir_ack_pulse: got %b expected 0", bus.o_ireq_ack); end
        m_last_data = 1'b0;
    endtask

    task automatic test_data_write();
        bit ok;
        bus.i_dreq_addr = 32'h0000_0020; bus.i_dreq_write = 1'b1; bus.i_dreq_read = 1'b1;
        bus.i_dreq_write_sel = 4'b0011; bus.i_dreq_write_data = 32'hAABB_CCDD;
        wait_grant(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL dw_grant: no grant within bound"); end
        n_cmp++;
        if ({bus.o_cache_write, bus.o_cache_read, bus.o_cache_write_sel, bus.o_grant} !== 8'b1_0_0011_10) begin
            n_bad++; $display("FAIL dw_strobes: got w%b r%b sel%b g%b expected w1 r0 sel0011 g10",
                bus.o_cache_write, bus.o_cache_read, bus.o_cache_write_sel, bus.o_grant);
        end
        n_cmp++;
        if ({bus.o_cache_addr, bus.o_cache_write_data} !== {32'h0000_0020, 32'hAABB_CCDD}) begin
            n_bad++; $display("FAIL dw_payload: got %h/%h expected 00000020/aabbccdd", bus.o_cache_addr, bus.o_cache_write_data);
        end
        bus.i_cache_ack = 1'b1; bus.i_cache_data = 32'hDEAD_BEEF;
        step();
        bus.i_cache_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_dreq_ack, bus.o_ireq_ack, bus.o_dreq_data} !== {2'b10, 32'h0}) begin
            n_bad++; $display("FAIL dw_ack: got dack%b iack%b data%h expected 1 0 00000000",
                bus.o_dreq_ack, bus.o_ireq_ack, bus.o_dreq_data);
        end
        n_cmp++;
        if (bus.o_ireq_data !== 32'h1234_5678) begin n_bad++; $display("FAIL dw_ihold: got %h expected 12345678", bus.o_ireq_data); end
        bus.i_dreq_write = 1'b0; bus.i_dreq_read = 1'b0;
        step();
        m_last_data = 1'b1;
    endtask

    task automatic test_contention();
        bit ok;
        bit exp_data;
        do_reset();
        bus.i_ireq_addr = 32'h0000_0100; bus.i_ireq_read = 1'b1;
        bus.i_dreq_addr = 32'h0000_0200; bus.i_dreq_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_data = !m_last_data;
            wait_grant(ok);
            n_cmp++;
            if (bus.o_grant !== {exp_data, !exp_data}) begin
                n_bad++; $display("FAIL cont_order[%0d]: got grant %b expected %b", k, bus.o_grant, {exp_data, !exp_data});
            end
            m_last_data = exp_data;
            bus.i_cache_ack = 1'b1; bus.i_cache_data = 32'hC000_0000 + k;
            step();
            bus.i_cache_ack = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({bus.o_dreq_ack, bus.o_ireq_ack} !== {exp_data, !exp_data}) begin
                n_bad++; $display("FAIL cont_ack[%0d]: got d%b i%b expected d%b i%b", k,
                    bus.o_dreq_ack, bus.o_ireq_ack, exp_data, !exp_data);
            end
        end
        idle_inputs();
        step(); step();
    endtask

    task automatic test_delayed_ack();
        bit ok;
        bit held = 1'b1;
        bus.i_dreq_addr = 32'h0000_0300; bus.i_dreq_read = 1'b1;
        wait_grant(ok);
        n_cmp++;
        if (bus.o_grant !== 2'b10) begin n_bad++; $display("FAIL dly_grant: got %b expected 10", bus.o_grant); end
        bus.i_dreq_addr = 32'h0000_0400; bus.i_dreq_write = 1'b1; bus.i_dreq_write_data = 32'h5555_AAAA;
        bus.i_ireq_read = 1'b1; bus.i_ireq_addr = 32'h0000_0500;
        for (int c = 1; c <= 5; c++) begin
            if ({bus.o_cache_addr, bus.o_cache_read, bus.o_cache_write, bus.o_cache_write_sel, bus.o_grant, bus.o_dreq_ack}
                !== {32'h0000_0300, 1'b1, 1'b0, 4'hF, 2'b10, 1'b0}) held = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (!held) begin n_bad++; $display("FAIL dly_hold: cache request changed mid-serve, expected addr 00000300 read"); end
        bus.i_cache_ack = 1'b1; bus.i_cache_data = 32'h0BAD_F00D;
        @(negedge clk);
        bus.i_cache_ack = 1'b0;
        n_cmp++;
        if ({bus.o_dreq_ack, bus.o_ireq_ack, bus.o_dreq_data} !== {2'b10, 32'h0BAD_F00D}) begin
            n_bad++; $display("FAIL dly_ack: got dack%b iack%b data%h expected 1 0 0badf00d",
                bus.o_dreq_ack, bus.o_ireq_ack, bus.o_dreq_data);
        end
        idle_inputs();
        step(); step();
        m_last_data = 1'b1;
    endtask

    task automatic test_watchdog(input bit ack_last);
        bit ok;
        bit quiet = 1'b1;
        bus.i_dreq_addr = 32'h0000_0600; bus.i_dreq_read = 1'b1;
        wait_grant(ok);
        for (int c = 1; c <= WD_LIMIT; c++) begin
            if ({bus.o_timeout, bus.o_dreq_ack, bus.o_cache_read} !== 3'b001) quiet = 1'b0;
            if (ack_last && c == WD_LIMIT) begin
                bus.i_cache_ack = 1'b1; bus.i_cache_data = 32'hFEED_0015;
            end
            @(negedge clk);
        end
        bus.i_cache_ack = 1'b0;
        n_cmp++;
        if (!quiet) begin n_bad++; $display("FAIL wd_early[%0d]: completion or timeout before cycle 15", ack_last); end
        n_cmp++;
        if ({bus.o_dreq_ack, bus.o_timeout, bus.o_cache_read} !== {1'b1, !ack_last, 1'b0}) begin
            n_bad++; $display("FAIL wd_end[%0d]: got dack%b to%b r%b expected 1 %b 0", ack_last,
                bus.o_dreq_ack, bus.o_timeout, bus.o_cache_read, !ack_last);
        end
        n_cmp++;
        if (bus.o_dreq_data !== (ack_last ? 32'hFEED_0015 : 32'h0)) begin
            n_bad++; $display("FAIL wd_data[%0d]: got %h expected %h", ack_last, bus.o_dreq_data, ack_last ? 32'hFEED_0015 : 32'h0);
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (bus.o_timeout !== 1'b0) begin n_bad++; $display("FAIL wd_pulse[%0d]: got %b expected 0", ack_last, bus.o_timeout); end
        step();
        m_last_data = 1'b1;
    endtask

    task automatic test_reset_mid_serve();
        bit ok;
        bit no_ack = 1'b1;
        bus.i_dreq_addr = 32'h1000_0000; bus.i_dreq_read = 1'b1;
        wait_grant(ok);
        n_cmp++;
        if ({bus.o_grant, bus.o_cache_read, bus.o_hit_ok} !== 4'b10_1_0) begin
            n_bad++; $display("FAIL rst_hit: got g%b r%b hit%b expected 10 1 0", bus.o_grant, bus.o_cache_read, bus.o_hit_ok);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.o_cache_read, bus.o_cache_write, bus.o_grant, bus.o_dreq_ack, bus.o_hit_ok} !== 6'b0) begin
            n_bad++; $display("FAIL rst_mid: got r%b w%b g%b dack%b hit%b expected all 0",
                bus.o_cache_read, bus.o_cache_write, bus.o_grant, bus.o_dreq_ack, bus.o_hit_ok);
        end
        rst = 1'b0;
        bus.i_dreq_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.o_dreq_ack !== 1'b0) no_ack = 1'b0;
        end
        n_cmp++;
        if (!no_ack) begin n_bad++; $display("FAIL rst_no_ack: got dack after reset expected none"); end
        step();
        m_last_data = 1'b1;
    endtask

    task automatic test_random();
        bit ok, ip, dp, wr, win_d, to, good;
        int rw, delay, errs;
        logic [31:0] ia, da, wd, rd, m_idata, m_ddata, exp_d;
        logic [3:0] sel;
        do_reset();
        m_idata = 0; m_ddata = 0; errs = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            ip = $urandom_range(0, 1);
            dp = ip ? $urandom_range(0, 1) : 1'b1;
            rw = $urandom_range(0, 2);
            wr = dp && (rw != 0);
            ia = $urandom; da = $urandom; wd = $urandom; rd = $urandom;
            sel = 4'($urandom);
            delay = $urandom_range(0, 16);
            to = (delay >= WD_LIMIT);
            bus.i_ireq_read = ip; bus.i_ireq_addr = ia;
            bus.i_dreq_addr = da; bus.i_dreq_write = wr; bus.i_dreq_read = dp && (rw != 1);
            bus.i_dreq_write_sel = sel; bus.i_dreq_write_data = wd;
            win_d = dp && (!ip || !m_last_data);
            m_last_data = win_d;
            wait_grant(ok);
            good = (bus.o_grant == {win_d, !win_d});
            if (win_d) good = good && bus.o_cache_addr == da && bus.o_cache_write == wr && bus.o_cache_read == !wr
                              && bus.o_cache_write_sel == (wr ? sel : 4'hF) && (!wr || bus.o_cache_write_data == wd);
            else       good = good && bus.o_cache_addr == ia && bus.o_cache_read && !bus.o_cache_write
                              && bus.o_cache_write_sel == 4'hF;
            good = good && (bus.o_hit_ok == (bus.o_cache_addr[31:28] == 4'h0));
            n_cmp++;
            if (!good) begin
                n_bad++; errs++;
                if (errs < 6) $display("FAIL rnd_req[%0d]: got g%b addr%h r%b w%b sel%h expected g%b", t,
                    bus.o_grant, bus.o_cache_addr, bus.o_cache_read, bus.o_cache_write, bus.o_cache_write_sel, {win_d, !win_d});
            end
            for (int c = 1; c <= WD_LIMIT; c++) begin
                if (!to && c == delay + 1) begin
                    bus.i_cache_ack = 1'b1; bus.i_cache_data = rd;
                    @(negedge clk);
                    break;
                end
                @(negedge clk);
            end
            bus.i_cache_ack = 1'b0;
            exp_d = (to || (win_d && wr)) ? 32'h0 : rd;
            if (win_d) m_ddata = exp_d; else m_idata = exp_d;
            n_cmp++;
            if ({bus.o_dreq_ack, bus.o_ireq_ack, bus.o_timeout, bus.o_ireq_data, bus.o_dreq_data}
                !== {win_d, !win_d, to, m_idata, m_ddata}) begin
                n_bad++; errs++;
                if (errs < 6) $display("FAIL rnd_done[%0d]: got d%b i%b to%b idata%h ddata%h expected d%b i%b to%b idata%h ddata%h",
                    t, bus.o_dreq_ack, bus.o_ireq_ack, bus.o_timeout, bus.o_ireq_data, bus.o_dreq_data,
                    win_d, !win_d, to, m_idata, m_ddata);
            end
            idle_inputs();
        end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_instr_read();
        test_data_write();
        test_contention();
        test_delayed_ack();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_reset_mid_serve();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
